// File: rtl/fm_stream_feeder_pkg.sv
// ---------------------------------------------------------------------------
// fm_stream_feeder_pkg
// Shared definitions for the feature-map stream feeder:
//   - default geometry / width parameters for the feeder
//   - FSM state type
//   - helper to size the raster coordinate counters
// ---------------------------------------------------------------------------
package fm_stream_feeder_pkg;

    localparam int FEEDER_FM_SIZE_DEF    = 4;
    localparam int FEEDER_PADDING_DEF    = 1;
    localparam int FEEDER_DATA_WIDTH_DEF = 16;
    localparam int FEEDER_ADDR_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_e;

    // Counter width able to hold 0..p_size (one beyond the last index).
    function automatic int cnt_width(input int p_size);
        return $clog2(p_size + 1);
    endfunction

endpackage

// File: rtl/fm_stream_feeder_if.sv
// ---------------------------------------------------------------------------
// fm_stream_feeder_if
// Bundles the feeder's control, BRAM read port and PE stream signals.
//   i_start / i_base_addr : transfer request and FM base address
//   o_rd_en / o_rd_addr   : BRAM read request (1-cycle read latency)
//   i_rd_data             : BRAM read data
//   o_data / o_en         : gap-free stream into the PE
//   o_busy / o_done       : transfer status
// master = the feeder, slave = its environment (controller, BRAM, PE).
// ---------------------------------------------------------------------------
interface fm_stream_feeder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  i_start;
    logic [ADDR_WIDTH-1:0] i_base_addr;
    logic                  o_rd_en;
    logic [ADDR_WIDTH-1:0] o_rd_addr;
    logic [DATA_WIDTH-1:0] i_rd_data;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_en;
    logic                  o_busy;
    logic                  o_done;

    modport master (
        input  i_start, i_base_addr, i_rd_data,
        output o_rd_en, o_rd_addr, o_data, o_en, o_busy, o_done
    );

    modport slave (
        output i_start, i_base_addr, i_rd_data,
        input  o_rd_en, o_rd_addr, o_data, o_en, o_busy, o_done
    );
endinterface

// File: rtl/fm_stream_feeder_coord_counter.sv
// ---------------------------------------------------------------------------
// fm_coord_counter
// Raster (row, col) counter over a P_SIZE x P_SIZE grid.
// Ports:
//   i_clk, i_rst        : clock, async active-high reset
//   i_clear             : restart at (0,0) on the next edge
//   i_advance           : step to the next raster coordinate
//   o_row_nxt/o_col_nxt : coordinate the counter will hold after this edge
//   o_wrap              : current column is the last one
//   o_last              : current coordinate is (P_SIZE-1, P_SIZE-1)
// The next-coordinate outputs let a user register per-coordinate outputs
// in the same edge that the coordinate becomes current.
// ---------------------------------------------------------------------------
module fm_coord_counter
    import fm_stream_feeder_pkg::*;
#(
    parameter  int P_SIZE = 6,
    localparam int CW     = cnt_width(P_SIZE)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_advance,
    output logic [CW-1:0] o_row_nxt,
    output logic [CW-1:0] o_col_nxt,
    output logic          o_wrap,
    output logic          o_last
);

    localparam logic [CW-1:0] LAST_IDX = CW'(P_SIZE - 1);

    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    assign o_wrap    = (col_q == LAST_IDX);
    assign o_last    = o_wrap && (row_q == LAST_IDX);
    assign o_row_nxt = row_d;
    assign o_col_nxt = col_d;

    // Next coordinate: clear has priority, column wrap carries into the row.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (i_clear) begin
            row_d = {CW{1'b0}};
            col_d = {CW{1'b0}};
        end else if (i_advance) begin
            if (o_wrap) begin
                col_d = {CW{1'b0}};
                row_d = row_q + CW'(1'b1);
            end else begin
                col_d = col_q + CW'(1'b1);
            end
        end else begin
            row_d = row_q;
            col_d = col_q;
        end
    end

    // Coordinate registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            row_q <= {CW{1'b0}};
            col_q <= {CW{1'b0}};
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/fm_stream_feeder.sv
// ---------------------------------------------------------------------------
// fm_stream_feeder
// Reads one FM_SIZE x FM_SIZE feature map from a synchronous BRAM in raster
// order, surrounds it with PADDING zero rows/columns and drives a gap-free
// (FM_SIZE+2*PADDING)^2-word stream into a PE (which has no backpressure
// and resets itself whenever o_en drops).
// Ports:
//   i_clk, i_rst : clock, async active-high reset
//   bus (master) : start/base, BRAM read port, PE stream, busy/done
// Timing with the accepted start in cycle 0 and N_OUT = P_SIZE^2:
//   reads on cycles 1..N_OUT, o_en on 2..N_OUT+1, o_done on N_OUT+2.
// ---------------------------------------------------------------------------
module fm_stream_feeder
    import fm_stream_feeder_pkg::*;
#(
    parameter int FM_SIZE    = FEEDER_FM_SIZE_DEF,
    parameter int PADDING    = FEEDER_PADDING_DEF,
    parameter int DATA_WIDTH = FEEDER_DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = FEEDER_ADDR_WIDTH_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    fm_stream_feeder_if.master bus
);

    localparam int P_SIZE = FM_SIZE + 2 * PADDING;
    localparam int CW     = cnt_width(P_SIZE);
    localparam int PW     = ADDR_WIDTH + $clog2(FM_SIZE * FM_SIZE);

    localparam logic [CW-1:0] PAD_LO = CW'(PADDING);
    localparam logic [CW-1:0] FM_LIM = CW'(FM_SIZE);

    feeder_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  valid_q, valid_d;
    logic                  pad_q, pad_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  cnt_clear_s;
    logic                  cnt_adv_s;
    logic                  cnt_last_s;
    logic                  wrap_unused_s;
    logic [CW-1:0]         row_nxt_s, col_nxt_s;
    logic [CW-1:0]         row_off_s, col_off_s;
    logic                  inb_nxt_s;
    logic                  issue_s;
    logic [ADDR_WIDTH-1:0] addr_calc_s;

    fm_coord_counter #(
        .P_SIZE (P_SIZE)
    ) u_coord (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (cnt_clear_s),
        .i_advance (cnt_adv_s),
        .o_row_nxt (row_nxt_s),
        .o_col_nxt (col_nxt_s),
        .o_wrap    (wrap_unused_s),
        .o_last    (cnt_last_s)
    );

    // Offsets into the unpadded map. A coordinate inside the top/left pad
    // wraps to a value >= FM_SIZE, so one unsigned compare per axis covers
    // both pad sides.
    assign row_off_s = row_nxt_s - PAD_LO;
    assign col_off_s = col_nxt_s - PAD_LO;
    assign inb_nxt_s = (row_off_s < FM_LIM) && (col_off_s < FM_LIM);

    // Address is formed wide and truncated, so it wraps modulo 2^ADDR_WIDTH.
    assign addr_calc_s = ADDR_WIDTH'(PW'(row_off_s) * PW'(FM_SIZE)
                                     + PW'(col_off_s) + PW'(base_d));

    // FSM next state, counter control and base latch.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        cnt_clear_s = 1'b0;
        cnt_adv_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d     = ST_STREAM;
                    base_d      = bus.i_base_addr;
                    cnt_clear_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (cnt_last_s) begin
                    state_d = ST_FLUSH;
                end else begin
                    cnt_adv_s = 1'b1;
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Registered outputs are computed from the coordinate that becomes
    // current on this edge, so reads appear in the first STREAM cycle.
    // The pad flag is simply the previous cycle's "no read issued".
    always_comb begin
        issue_s   = (state_d == ST_STREAM) && inb_nxt_s;
        rd_en_d   = issue_s;
        rd_addr_d = issue_s ? addr_calc_s : rd_addr_q;
        valid_d   = (state_q == ST_STREAM);
        pad_d     = (state_q == ST_STREAM) && !rd_en_q;
        busy_d    = (state_d == ST_STREAM) || (state_d == ST_FLUSH);
        done_d    = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            base_q    <= {ADDR_WIDTH{1'b0}};
            rd_en_q   <= 1'b0;
            rd_addr_q <= {ADDR_WIDTH{1'b0}};
            valid_q   <= 1'b0;
            pad_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            valid_q   <= valid_d;
            pad_q     <= pad_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.o_rd_en   = rd_en_q;
    assign bus.o_rd_addr = rd_addr_q;
    assign bus.o_en      = valid_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
    // BRAM data passes straight through so the stream adds no extra cycle.
    assign bus.o_data    = (valid_q && !pad_q) ? bus.i_rd_data : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_fm_stream_feeder.sv
// ---------------------------------------------------------------------------
// tb_fm_stream_feeder
// Three feeder instances share one clock/reset:
//   u_a : FM_SIZE=4, PADDING=1, 16-bit address
//   u_b : FM_SIZE=3, PADDING=0, 16-bit address
//   u_c : FM_SIZE=3, PADDING=0, 8-bit address (wrap-around)
// Each BRAM model returns addr+1 one cycle after a read. Expected stream
// words are queued when a start is driven and popped on every o_en cycle.
// Cycle k: inputs driven and outputs sampled at the k-th falling edge.
// ---------------------------------------------------------------------------
module tb_fm_stream_feeder;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [15:0] q_a[$];
    logic [15:0] q_b_addr[$];
    logic [15:0] q_b_data[$];
    logic [7:0]  q_c_addr[$];
    logic [15:0] q_c_data[$];

    fm_stream_feeder_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) a_if();
    fm_stream_feeder_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) b_if();
    fm_stream_feeder_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8))  c_if();

    fm_stream_feeder #(.FM_SIZE(4), .PADDING(1), .DATA_WIDTH(16), .ADDR_WIDTH(16))
        u_a (.i_clk(clk), .i_rst(rst), .bus(a_if));
    fm_stream_feeder #(.FM_SIZE(3), .PADDING(0), .DATA_WIDTH(16), .ADDR_WIDTH(16))
        u_b (.i_clk(clk), .i_rst(rst), .bus(b_if));
    fm_stream_feeder #(.FM_SIZE(3), .PADDING(0), .DATA_WIDTH(16), .ADDR_WIDTH(8))
        u_c (.i_clk(clk), .i_rst(rst), .bus(c_if));

    always #5 clk = ~clk;

    // BRAM models: data = address + 1, one-cycle read latency.
    always_ff @(posedge clk) begin
        if (a_if.o_rd_en) a_if.i_rd_data <= a_if.o_rd_addr + 16'd1;
        if (b_if.o_rd_en) b_if.i_rd_data <= b_if.o_rd_addr + 16'd1;
        if (c_if.o_rd_en) c_if.i_rd_data <= {8'd0, c_if.o_rd_addr} + 16'd1;
    end

    // Expected padded 6x6 stream of u_a for base 0.
    task automatic push_a_frame();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                if (r == 0 || r == 5 || c == 0 || c == 5) q_a.push_back(16'd0);
                else q_a.push_back(16'((r - 1) * 4 + (c - 1) + 1));
            end
        end
    endtask

    // Runs one (or two back-to-back) u_a transfers and checks every cycle.
    task automatic run_stream_a(input string tag, input int repulse, input bit b2b);
        int          en_cnt;
        int          done_cnt;
        int          n_xfer;
        int          last_k;
        bit          exp_busy, exp_en, exp_done;
        logic [15:0] exp_d;
        en_cnt   = 0;
        done_cnt = 0;
        n_xfer   = b2b ? 2 : 1;
        last_k   = b2b ? 80 : 41;
        a_if.i_base_addr = 16'd0;
        @(negedge clk);
        push_a_frame();
        a_if.i_start = 1'b1;
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            exp_busy = (k >= 1 && k <= 37) || (b2b && k >= 40 && k <= 76);
            exp_en   = (k >= 2 && k <= 37) || (b2b && k >= 41 && k <= 76);
            exp_done = (k == 38) || (b2b && k == 77);
            checks += 3;
            if (a_if.o_busy !== exp_busy) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b expected %b", tag, k, a_if.o_busy, exp_busy);
            end
            if (a_if.o_en !== exp_en) begin
                errors++;
                $display("FAIL %s en cycle %0d: got %b expected %b", tag, k, a_if.o_en, exp_en);
            end
            if (a_if.o_done !== exp_done) begin
                errors++;
                $display("FAIL %s done cycle %0d: got %b expected %b", tag, k, a_if.o_done, exp_done);
            end
            checks++;
            if (a_if.o_en === 1'b1) begin
                en_cnt++;
                if (q_a.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra word cycle %0d: got %0d expected none", tag, k, a_if.o_data);
                end else begin
                    exp_d = q_a.pop_front();
                    if (a_if.o_data !== exp_d) begin
                        errors++;
                        $display("FAIL %s data cycle %0d: got %0d expected %0d", tag, k, a_if.o_data, exp_d);
                    end
                end
            end else if (a_if.o_data !== 16'd0) begin
                errors++;
                $display("FAIL %s idle data cycle %0d: got %0d expected 0", tag, k, a_if.o_data);
            end
            if (a_if.o_done === 1'b1) done_cnt++;
            if (k == repulse || (b2b && k == 38)) begin
                a_if.i_start = 1'b1;
            end else if (b2b && k == 39) begin
                push_a_frame();
                a_if.i_start = 1'b1;
            end else begin
                a_if.i_start = 1'b0;
            end
        end
        checks += 3;
        if (en_cnt != 36 * n_xfer) begin
            errors++;
            $display("FAIL %s en count: got %0d expected %0d", tag, en_cnt, 36 * n_xfer);
        end
        if (done_cnt != n_xfer) begin
            errors++;
            $display("FAIL %s done count: got %0d expected %0d", tag, done_cnt, n_xfer);
        end
        if (q_a.size() != 0) begin
            errors++;
            $display("FAIL %s missing words: got %0d left expected 0", tag, q_a.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 8;
        if (a_if.o_en !== 1'b0)       begin errors++; $display("FAIL reset en: got %b expected 0", a_if.o_en); end
        if (a_if.o_data !== 16'd0)    begin errors++; $display("FAIL reset data: got %0d expected 0", a_if.o_data); end
        if (a_if.o_rd_en !== 1'b0)    begin errors++; $display("FAIL reset rd_en: got %b expected 0", a_if.o_rd_en); end
        if (a_if.o_rd_addr !== 16'd0) begin errors++; $display("FAIL reset rd_addr: got %0d expected 0", a_if.o_rd_addr); end
        if (a_if.o_busy !== 1'b0)     begin errors++; $display("FAIL reset busy: got %b expected 0", a_if.o_busy); end
        if (a_if.o_done !== 1'b0)     begin errors++; $display("FAIL reset done: got %b expected 0", a_if.o_done); end
        if (b_if.o_busy !== 1'b0)     begin errors++; $display("FAIL reset busy_b: got %b expected 0", b_if.o_busy); end
        if (c_if.o_rd_addr !== 8'd0)  begin errors++; $display("FAIL reset rd_addr_c: got %0d expected 0", c_if.o_rd_addr); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (a_if.o_busy !== 1'b0) begin errors++; $display("FAIL idle busy: got %b expected 0", a_if.o_busy); end
    endtask

    task automatic test_padded_stream();
        run_stream_a("padded", -1, 1'b0);
    endtask

    task automatic test_restart_ignored();
        run_stream_a("restart", 5, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_stream_a("b2b", -1, 1'b1);
    endtask

    task automatic test_no_pad();
        logic [15:0] e;
        b_if.i_base_addr = 16'd100;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            q_b_addr.push_back(16'(100 + i));
            q_b_data.push_back(16'(101 + i));
        end
        b_if.i_start = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            b_if.i_start = 1'b0;
            checks += 4;
            if (b_if.o_rd_en !== (k >= 1 && k <= 9)) begin errors++; $display("FAIL nopad rd_en cycle %0d: got %b", k, b_if.o_rd_en); end
            if (b_if.o_en !== (k >= 2 && k <= 10))   begin errors++; $display("FAIL nopad en cycle %0d: got %b", k, b_if.o_en); end
            if (b_if.o_busy !== (k >= 1 && k <= 10)) begin errors++; $display("FAIL nopad busy cycle %0d: got %b", k, b_if.o_busy); end
            if (b_if.o_done !== (k == 11))           begin errors++; $display("FAIL nopad done cycle %0d: got %b", k, b_if.o_done); end
            if (b_if.o_rd_en === 1'b1) begin
                checks++;
                if (q_b_addr.size() == 0) begin
                    errors++; $display("FAIL nopad extra addr cycle %0d: got %0d", k, b_if.o_rd_addr);
                end else begin
                    e = q_b_addr.pop_front();
                    if (b_if.o_rd_addr !== e) begin errors++; $display("FAIL nopad addr cycle %0d: got %0d expected %0d", k, b_if.o_rd_addr, e); end
                end
            end
            if (b_if.o_en === 1'b1) begin
                checks++;
                if (q_b_data.size() == 0) begin
                    errors++; $display("FAIL nopad extra data cycle %0d: got %0d", k, b_if.o_data);
                end else begin
                    e = q_b_data.pop_front();
                    if (b_if.o_data !== e) begin errors++; $display("FAIL nopad data cycle %0d: got %0d expected %0d", k, b_if.o_data, e); end
                end
            end
        end
        checks++;
        if (q_b_addr.size() + q_b_data.size() != 0) begin
            errors++; $display("FAIL nopad leftover: got %0d expected 0", q_b_addr.size() + q_b_data.size());
        end
    endtask

    task automatic test_addr_wrap();
        logic [7:0]  ea;
        logic [15:0] ed;
        c_if.i_base_addr = 8'd250;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            ea = 8'(250 + i);
            q_c_addr.push_back(ea);
            q_c_data.push_back({8'd0, ea} + 16'd1);
        end
        c_if.i_start = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            c_if.i_start = 1'b0;
            checks += 2;
            if (c_if.o_rd_en !== (k >= 1 && k <= 9)) begin errors++; $display("FAIL wrap rd_en cycle %0d: got %b", k, c_if.o_rd_en); end
            if (c_if.o_done !== (k == 11))           begin errors++; $display("FAIL wrap done cycle %0d: got %b", k, c_if.o_done); end
            if (c_if.o_rd_en === 1'b1) begin
                checks++;
                if (q_c_addr.size() == 0) begin
                    errors++; $display("FAIL wrap extra addr cycle %0d: got %0d", k, c_if.o_rd_addr);
                end else begin
                    ea = q_c_addr.pop_front();
                    if (c_if.o_rd_addr !== ea) begin errors++; $display("FAIL wrap addr cycle %0d: got %0d expected %0d", k, c_if.o_rd_addr, ea); end
                end
            end
            if (c_if.o_en === 1'b1) begin
                checks++;
                if (q_c_data.size() == 0) begin
                    errors++; $display("FAIL wrap extra data cycle %0d: got %0d", k, c_if.o_data);
                end else begin
                    ed = q_c_data.pop_front();
                    if (c_if.o_data !== ed) begin errors++; $display("FAIL wrap data cycle %0d: got %0d expected %0d", k, c_if.o_data, ed); end
                end
            end
        end
        checks++;
        if (q_c_addr.size() + q_c_data.size() != 0) begin
            errors++; $display("FAIL wrap leftover: got %0d expected 0", q_c_addr.size() + q_c_data.size());
        end
    endtask

    task automatic test_async_reset();
        int done_seen;
        done_seen = 0;
        a_if.i_base_addr = 16'd0;
        @(negedge clk);
        a_if.i_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            a_if.i_start = 1'b0;
        end
        checks++;
        if (a_if.o_en !== 1'b1) begin errors++; $display("FAIL arst pre en: got %b expected 1", a_if.o_en); end
        rst = 1'b1;
        #1;
        checks += 4;
        if (a_if.o_en !== 1'b0)    begin errors++; $display("FAIL arst en: got %b expected 0", a_if.o_en); end
        if (a_if.o_busy !== 1'b0)  begin errors++; $display("FAIL arst busy: got %b expected 0", a_if.o_busy); end
        if (a_if.o_rd_en !== 1'b0) begin errors++; $display("FAIL arst rd_en: got %b expected 0", a_if.o_rd_en); end
        if (a_if.o_data !== 16'd0) begin errors++; $display("FAIL arst data: got %0d expected 0", a_if.o_data); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (a_if.o_done === 1'b1) done_seen++;
        end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (a_if.o_done === 1'b1) done_seen++;
            checks++;
            if (a_if.o_busy !== 1'b0) begin errors++; $display("FAIL arst idle busy %0d: got %b expected 0", k, a_if.o_busy); end
        end
        checks++;
        if (done_seen != 0) begin errors++; $display("FAIL arst done pulses: got %0d expected 0", done_seen); end
        run_stream_a("after_reset", -1, 1'b0);
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b1;
        checks = 0;
        errors = 0;
        a_if.i_start = 1'b0; a_if.i_base_addr = 16'd0;
        b_if.i_start = 1'b0; b_if.i_base_addr = 16'd0;
        c_if.i_start = 1'b0; c_if.i_base_addr = 8'd0;
        test_reset();
        test_padded_stream();
        test_restart_ignored();
        test_no_pad();
        test_addr_wrap();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
